// File: rtl/sprite_mem_pkg.sv
// sprite_mem_pkg: shared types and constants for the sprite data-segment RAM.
// Last-owner encoding for the arbiter return path plus region bounds used by the sprite processor.
package sprite_mem_pkg;
   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;
   localparam int ATTR_BASE = 1024;
   localparam int ATTR_END = 1279;
   typedef enum logic [1:0] {NONE, VID_RD, CPU_RD, CPU_WR} last_t;
endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// sprite_ram_arbiter_if: video, CPU and RAM bus bundle around the arbiter.
// slave is the arbiter view; master is the requester/RAM side.
interface sprite_ram_arbiter_if import sprite_mem_pkg::*; #(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          vid_req;
   logic          vid_lock;
   logic [AW-1:0] vid_addr;
   logic          vid_gnt;
   logic          vid_rvalid;
   logic [DW-1:0] vid_rdata;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_q;
   modport slave (
      input  vid_req, vid_lock, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
      output vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             ram_addr, ram_wren, ram_wdata
   );
   modport master (
      output vid_req, vid_lock, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
      input  vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             ram_addr, ram_wren, ram_wdata
   );
endinterface

// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: single-port RAM arbiter, video priority with CPU starvation override.
// Grants are combinational; the registered last owner steers the 1-cycle read return.
module sprite_ram_arbiter import sprite_mem_pkg::*; #(
   parameter int MAX_WAIT = 8,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input logic clk,
   input logic rst,
   sprite_ram_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] r_wait;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   last_t         r_last;
   last_t         w_last;
   logic          w_force;
   logic          w_vgnt;
   logic          w_cgnt;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   assign w_force = bus.cpu_req & ~bus.vid_lock & (r_wait == CW'(MAX_WAIT));
   assign w_vgnt = ~rst & bus.vid_req & ~w_force;
   assign w_cgnt = ~rst & bus.cpu_req & ~w_vgnt;
   assign w_addr = w_vgnt ? bus.vid_addr : w_cgnt ? bus.cpu_addr : r_addr;
   assign w_wdata = w_cgnt ? bus.cpu_wdata : r_wdata;
   assign bus.vid_gnt = w_vgnt;
   assign bus.cpu_gnt = w_cgnt;
   assign bus.ram_addr = w_addr;
   assign bus.ram_wdata = w_wdata;
   assign bus.ram_wren = w_cgnt & bus.cpu_we;
   // rst gating drops a read already in flight when reset lands on its return cycle
   assign bus.vid_rvalid = ~rst & (r_last == VID_RD);
   assign bus.cpu_rvalid = ~rst & (r_last == CPU_RD);
   assign bus.vid_rdata = bus.ram_q;
   assign bus.cpu_rdata = bus.ram_q;
   always_comb begin
      w_last = NONE;
      w_last = w_vgnt ? VID_RD : w_cgnt ? (bus.cpu_we ? CPU_WR : CPU_RD) : NONE;
   end
   always_ff @(posedge clk) begin
      r_last <= rst ? NONE : w_last;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait <= '0;
         r_addr <= '0;
         r_wdata <= '0;
      end else begin
         r_wait <= (~bus.cpu_req | w_cgnt) ? '0 : (r_wait == CW'(MAX_WAIT)) ? r_wait : r_wait + 1'b1;
         r_addr <= w_addr;
         r_wdata <= w_wdata;
      end
   end
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// tb_sprite_ram_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_sprite_ram_arbiter;
   import sprite_mem_pkg::*;
   localparam int MW = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   sprite_ram_arbiter_if #(.AW(16), .DW(16)) bus ();
   sprite_ram_arbiter_if #(.AW(16), .DW(16)) bus1 ();
   sprite_ram_arbiter #(.MAX_WAIT(MW), .AW(16), .DW(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   sprite_ram_arbiter #(.MAX_WAIT(1), .AW(16), .DW(16)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   bit [15:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.ram_wren) mem[bus.ram_addr[11:0]] <= bus.ram_wdata;
      bus.ram_q <= mem[bus.ram_addr[11:0]];
   end
   assign bus1.ram_q = '0;
   int errs = 0;
   int checks = 0;
   // reference model: denial streak, pending read returns, shadow memory
   int m_wait = 0;
   bit m_vpend = 0, m_cpend = 0;
   logic [15:0] m_vexp = '0, m_cexp = '0, m_addr = '0, m_wdata = '0;
   bit [15:0] smem [int];
   bit e_vgnt, e_cgnt, e_vrv, e_crv, e_wren;
   logic [15:0] e_addr, e_wdata;
   function automatic bit [15:0] rd(logic [15:0] a);
      return smem.exists(int'(a[11:0])) ? smem[int'(a[11:0])] : 16'h0;
   endfunction
   task automatic sample();
      bit frc;
      @(negedge clk);
      frc = bus.cpu_req && !bus.vid_lock && m_wait >= MW;
      e_vgnt = !rst && bus.vid_req && !frc;
      e_cgnt = !rst && bus.cpu_req && !e_vgnt;
      e_vrv = m_vpend && !rst;
      e_crv = m_cpend && !rst;
      e_addr = e_vgnt ? bus.vid_addr : e_cgnt ? bus.cpu_addr : m_addr;
      e_wren = e_cgnt && bus.cpu_we;
      e_wdata = e_cgnt ? bus.cpu_wdata : m_wdata;
   endtask
   task automatic advance();
      if (rst) begin
         m_wait = 0; m_vpend = 0; m_cpend = 0; m_addr = '0; m_wdata = '0;
      end else begin
         m_vpend = e_vgnt;
         m_vexp = rd(bus.vid_addr);
         m_cpend = e_cgnt && !bus.cpu_we;
         m_cexp = rd(bus.cpu_addr);
         if (e_wren) smem[int'(bus.cpu_addr[11:0])] = bus.cpu_wdata;
         m_wait = (!bus.cpu_req || e_cgnt) ? 0 : (m_wait < MW ? m_wait + 1 : MW);
         m_addr = e_addr;
         m_wdata = e_wdata;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      bus.vid_req = 1; bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'd1030; bus.cpu_wdata = 16'h5555;
      sample();
      checks++;
      if ({bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren} !== 5'b0) begin
         errs++; $display("FAIL reset_ctl got %b want 00000", {bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren});
      end
      checks++;
      if (bus.ram_addr !== 16'h0) begin errs++; $display("FAIL reset_addr got %h want 0000", bus.ram_addr); end
      checks++;
      if (bus.ram_wdata !== 16'h0) begin errs++; $display("FAIL reset_wdata got %h want 0000", bus.ram_wdata); end
      advance();
      rst = 0; bus.vid_req = 0; bus.cpu_req = 0; bus.cpu_we = 0;
      sample();
      checks++;
      if ({bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren} !== 3'b0 || bus.ram_addr !== 16'h0) begin
         errs++; $display("FAIL reset_exit got rv=%b%b wren=%b addr=%h want 000 0000", bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren, bus.ram_addr);
      end
      advance();
   endtask
   task automatic test_cpu_only();
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'd1030; bus.cpu_wdata = 16'h1234;
      sample();
      checks++;
      if ({bus.cpu_gnt, bus.vid_gnt, bus.ram_wren} !== 3'b101 || bus.ram_addr !== 16'd1030 || bus.ram_wdata !== 16'h1234) begin
         errs++; $display("FAIL cpu_wr got gnt=%b vg=%b wren=%b addr=%0d wd=%h want 1 0 1 1030 1234", bus.cpu_gnt, bus.vid_gnt, bus.ram_wren, bus.ram_addr, bus.ram_wdata);
      end
      advance();
      bus.cpu_we = 0;
      sample();
      checks++;
      if ({bus.cpu_gnt, bus.cpu_rvalid, bus.ram_wren} !== 3'b100) begin
         errs++; $display("FAIL cpu_rd got gnt=%b rvalid=%b wren=%b want 1 0 0", bus.cpu_gnt, bus.cpu_rvalid, bus.ram_wren);
      end
      advance();
      bus.cpu_req = 0;
      sample();
      checks++;
      if ({bus.cpu_rvalid, bus.vid_rvalid} !== 2'b10 || bus.cpu_rdata !== 16'h1234) begin
         errs++; $display("FAIL cpu_ret got rv=%b vrv=%b data=%h want 1 0 1234", bus.cpu_rvalid, bus.vid_rvalid, bus.cpu_rdata);
      end
      checks++;
      if (bus.ram_addr !== 16'd1030 || bus.ram_wren !== 1'b0) begin
         errs++; $display("FAIL idle_hold got addr=%0d wren=%b want 1030 0", bus.ram_addr, bus.ram_wren);
      end
      advance();
      sample();
      checks++;
      if (bus.cpu_rvalid !== 1'b0) begin errs++; $display("FAIL cpu_ret_once got %b want 0", bus.cpu_rvalid); end
      advance();
   endtask
   task automatic test_contention();
      bit ev;
      for (int i = 1; i <= 10; i++) begin
         bus.vid_req = 1; bus.vid_lock = 0; bus.vid_addr = 16'(ATTR_BASE + i);
         bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'(ATTR_END);
         sample();
         ev = (i != 9);
         checks++;
         if ({bus.vid_gnt, bus.cpu_gnt} !== {ev, !ev}) begin
            errs++; $display("FAIL contend_gnt cycle %0d got %b%b want %b%b", i, bus.vid_gnt, bus.cpu_gnt, ev, !ev);
         end
         checks++;
         if (int'(u_dut.r_wait) != (i <= 9 ? i - 1 : 0)) begin
            errs++; $display("FAIL contend_wait cycle %0d got %0d want %0d", i, u_dut.r_wait, (i <= 9 ? i - 1 : 0));
         end
         checks++;
         if ({bus.vid_rvalid, bus.cpu_rvalid} !== {e_vrv, e_crv}) begin
            errs++; $display("FAIL contend_rv cycle %0d got %b%b want %b%b", i, bus.vid_rvalid, bus.cpu_rvalid, e_vrv, e_crv);
         end
         advance();
      end
      bus.vid_req = 0; bus.cpu_req = 0;
      sample(); advance();
   endtask
   task automatic test_lock();
      for (int i = 1; i <= 21; i++) begin
         bus.vid_req = 1; bus.vid_lock = (i <= 20); bus.vid_addr = 16'(ATTR_BASE + i);
         bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd1030;
         sample();
         checks++;
         if ({bus.vid_gnt, bus.cpu_gnt} !== {i != 21, i == 21}) begin
            errs++; $display("FAIL lock_gnt cycle %0d got %b%b want %b%b", i, bus.vid_gnt, bus.cpu_gnt, i != 21, i == 21);
         end
         checks++;
         if (int'(u_dut.r_wait) != (i - 1 < MW ? i - 1 : MW)) begin
            errs++; $display("FAIL lock_wait cycle %0d got %0d want %0d", i, u_dut.r_wait, (i - 1 < MW ? i - 1 : MW));
         end
         advance();
      end
      bus.vid_req = 0; bus.vid_lock = 0; bus.cpu_req = 0;
      sample(); advance();
   endtask
   task automatic test_interleave();
      bit [6:0] vr = 7'b0111011;
      bit [6:0] cr = 7'b0000111;
      int va [7] = '{1024, 1025, 0, 1026, 1027, 1025, 0};
      for (int i = 0; i < 7; i++) begin
         bus.vid_req = vr[i]; bus.vid_addr = 16'(va[i]);
         bus.cpu_req = cr[i]; bus.cpu_we = 1; bus.cpu_addr = 16'd1025; bus.cpu_wdata = 16'hBEEF;
         sample();
         checks++;
         if ({bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid} !== {e_vgnt, e_cgnt, e_vrv, e_crv}) begin
            errs++; $display("FAIL ilv_route cycle %0d got %b%b%b%b want %b%b%b%b", i, bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid, e_vgnt, e_cgnt, e_vrv, e_crv);
         end
         if (e_vrv) begin
            checks++;
            if (bus.vid_rdata !== m_vexp) begin errs++; $display("FAIL ilv_data cycle %0d got %h want %h", i, bus.vid_rdata, m_vexp); end
         end
         if (i == 6) begin
            checks++;
            if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 16'hBEEF) begin
               errs++; $display("FAIL ilv_new_data got rv=%b data=%h want 1 beef", bus.vid_rvalid, bus.vid_rdata);
            end
         end
         advance();
      end
   endtask
   task automatic test_reset_mid_read();
      bus.vid_req = 1; bus.vid_addr = 16'd1026; bus.cpu_req = 0;
      sample();
      checks++;
      if (bus.vid_gnt !== 1'b1) begin errs++; $display("FAIL rstmid_gnt got %b want 1", bus.vid_gnt); end
      advance();
      bus.vid_req = 0; rst = 1;
      sample();
      checks++;
      if (bus.vid_rvalid !== 1'b0) begin errs++; $display("FAIL rstmid_rv got %b want 0", bus.vid_rvalid); end
      advance();
      rst = 0;
      sample();
      checks++;
      if ({bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren} !== 5'b0 || bus.ram_addr !== 16'h0 || bus.ram_wdata !== 16'h0) begin
         errs++; $display("FAIL rstmid_outs got ctl=%b addr=%h wd=%h want 00000 0000 0000", {bus.vid_gnt, bus.cpu_gnt, bus.vid_rvalid, bus.cpu_rvalid, bus.ram_wren}, bus.ram_addr, bus.ram_wdata);
      end
      advance();
   endtask
   task automatic test_max_wait_1();
      for (int i = 1; i <= 10; i++) begin
         bus1.vid_req = 1; bus1.vid_lock = 0; bus1.vid_addr = 16'(ATTR_BASE + i);
         bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'(ATTR_END - i);
         sample();
         checks++;
         if ({bus1.vid_gnt, bus1.cpu_gnt} !== {i % 2 == 1, i % 2 == 0}) begin
            errs++; $display("FAIL mw1_alt cycle %0d got %b%b want %b%b", i, bus1.vid_gnt, bus1.cpu_gnt, i % 2 == 1, i % 2 == 0);
         end
         advance();
      end
      bus1.vid_req = 0; bus1.cpu_req = 0;
   endtask
   task automatic test_random();
      int lk = 0;
      bit vg, cg;
      for (int n = 0; n < 400; n++) begin
         sample();
         checks++;
         if ({bus.vid_gnt, bus.cpu_gnt} !== {e_vgnt, e_cgnt}) begin
            errs++; $display("FAIL rnd_gnt n=%0d got %b%b want %b%b", n, bus.vid_gnt, bus.cpu_gnt, e_vgnt, e_cgnt);
         end
         checks++;
         if ({bus.vid_rvalid, bus.cpu_rvalid} !== {e_vrv, e_crv}) begin
            errs++; $display("FAIL rnd_rv n=%0d got %b%b want %b%b", n, bus.vid_rvalid, bus.cpu_rvalid, e_vrv, e_crv);
         end
         if (e_vrv) begin
            checks++;
            if (bus.vid_rdata !== m_vexp) begin errs++; $display("FAIL rnd_vdata n=%0d got %h want %h", n, bus.vid_rdata, m_vexp); end
         end
         if (e_crv) begin
            checks++;
            if (bus.cpu_rdata !== m_cexp) begin errs++; $display("FAIL rnd_cdata n=%0d got %h want %h", n, bus.cpu_rdata, m_cexp); end
         end
         checks++;
         if (bus.ram_addr !== e_addr || bus.ram_wren !== e_wren) begin
            errs++; $display("FAIL rnd_port n=%0d got addr=%h wren=%b want %h %b", n, bus.ram_addr, bus.ram_wren, e_addr, e_wren);
         end
         if (e_wren) begin
            checks++;
            if (bus.ram_wdata !== e_wdata) begin errs++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, bus.ram_wdata, e_wdata); end
         end
         vg = e_vgnt; cg = e_cgnt;
         advance();
         if (!bus.vid_req || vg) begin
            bus.vid_req = $urandom_range(0, 3) != 0;
            bus.vid_addr = 16'(ATTR_BASE + $urandom_range(0, 15));
         end
         if (!bus.cpu_req || cg) begin
            bus.cpu_req = 1'($urandom_range(0, 1));
            bus.cpu_we = 1'($urandom_range(0, 1));
            bus.cpu_addr = 16'(ATTR_BASE + $urandom_range(0, 15));
            bus.cpu_wdata = 16'($urandom);
         end
         if (lk > 0) lk--;
         else if ($urandom_range(0, 19) == 0) lk = $urandom_range(3, 12);
         bus.vid_lock = lk > 0;
      end
   endtask
   initial begin
      bus.vid_req = 0; bus.vid_lock = 0; bus.vid_addr = '0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus1.vid_req = 0; bus1.vid_lock = 0; bus1.vid_addr = '0;
      bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_cpu_only();
      test_contention();
      test_lock();
      test_interleave();
      test_reset_mid_read();
      test_max_wait_1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
